lab1_sweep_controller: RTL and testbench
========================================

// Module: lab1_sweep_controller
// PURPOSE
//  Sequencer that sweeps all 16 input vectors {A,B,C,D} through the Lab1 4-input
//  combinational function and captures F into a 16-bit truth table.
//  Sits between a host/test harness (start/done handshake) and one Lab1 function
//  instance. Replaces hand-written per-vector stimulus with a self-timed hardware sweep.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before F is sampled; legal range 1..15
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  start           in   1   single-cycle request to begin a sweep; honoured only in IDLE
//  abort           in   1   synchronous sweep cancel; honoured only while busy
//  f               in   1   F output of the Lab1 function under control
//  expected_table  in   16  golden truth table, bit i = F for vec i (used only with LAB1_SWEEP_CHECK_EN)
//  a, b, c, d      out  1   registered function inputs; vec = {a,b,c,d}, a is MSB
//  busy            out  1   high from the cycle after start is accepted until done
//  done            out  1   one-cycle pulse when a full sweep completes
//  truth_table     out  16  bit i = sampled F for vec i; held until the next accepted start
//  mismatch        out  1   truth_table != expected_table, valid with done and held after it
// BEHAVIOUR
//  Reset: state=IDLE; a=b=c=d=0; busy=0; done=0; truth_table=16'h0000; mismatch=0;
//   settle counter and vector index cleared. Reset is async, effective mid-sweep.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE:   start=1 -> vec<=0, idx<=0, truth_table<=0, mismatch<=0, busy<=1, go to SETTLE.
//  SETTLE: counts SETTLE_CYCLES cycles with vec held stable, then goes to SAMPLE.
//  SAMPLE: 1 cycle; truth_table[idx]<=f. If idx==15 go to DONE; else idx<=idx+1,
//          vec<=idx+1, settle counter cleared, go to SETTLE.
//  DONE:   1 cycle; done=1, busy<=0, mismatch updated; then IDLE. vec stays at 4'b1111.
//  Per-vector cost is SETTLE_CYCLES+1 cycles. done asserts exactly 16*(SETTLE_CYCLES+1)
//   cycles after the edge that accepts start (48 with the default).
//  start while busy or in DONE: ignored; no restart and no queuing.
//  abort while busy: next edge -> IDLE, busy=0, no done pulse, vec<=0. truth_table keeps
//   the partial bits captured so far; uncaptured bits remain 0.
//  abort and start both high in IDLE: start wins, because abort is ignored in IDLE.
//  idx is 4 bits and never wraps inside a sweep; DONE is the only exit after idx 15.
// CONFIGURATION
//  LAB1_SWEEP_CHECK_EN defined: in DONE, mismatch <= (truth_table_final != expected_table).
//   truth_table_final includes the bit-15 sample. mismatch holds until the next start or reset.
//  LAB1_SWEEP_CHECK_EN undefined: mismatch is tied to 0 and expected_table is unused.
//   The port list is identical in both builds.
// STRUCTURE
//  Shared header lab1_defs.vh holds:
//   - state encodings: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3
//   - LAB1_NUM_VECTORS=16 and LAB1_VEC_W=4
//  No sub-module inside the controller. The Lab1 function instance lives in a thin wrapper,
//   lab1_sweep_top, which connects a/b/c/d/f between the controller and the function.
// TESTING
//  1. Stub f=a&b, start pulse -> done at cycle 48, truth_table=16'hF000, busy high cycles 1..47.
//  2. Stub f=a^b^c^d, SETTLE_CYCLES=1 -> done at cycle 32, truth_table=16'h6996.
//  3. start pulsed again at cycle 10 of a sweep -> ignored; done still at cycle 48, one pulse only.
//  4. abort at cycle 20 (f=1) -> busy=0 next cycle, no done; truth_table=16'h003F (vecs 0..5 captured).
//  5. rst_n low at cycle 25 -> all outputs at reset values immediately; new start gives a clean full sweep.
//  6. CHECK_EN, f=a&b, expected_table=16'hF000 -> mismatch=0; expected_table=16'hF001 -> mismatch=1 with done.

Source files
------------

// File: rtl/lab1_sweep_controller_pkg.sv
// Shared definitions for the Lab1 truth-table sweep controller: FSM state
// encoding and sweep geometry.
package lab1_sweep_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam int unsigned LAB1_NUM_VECTORS = 16;
  localparam int unsigned LAB1_VEC_W       = 4;

endpackage

// File: rtl/lab1_sweep_controller.sv
// Lab1 sweep controller: drives all 16 {a,b,c,d} vectors into the Lab1
// function, holds each for SETTLE_CYCLES cycles, samples f and builds a
// 16-bit truth table. Optional golden-table compare enabled by the macro
// LAB1_SWEEP_CHECK_EN; without it, mismatch is constant 0.
module lab1_sweep_controller
  import lab1_sweep_controller_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        f,
  input  logic [LAB1_NUM_VECTORS-1:0] expected_table,
  output logic                        a,
  output logic                        b,
  output logic                        c,
  output logic                        d,
  output logic                        busy,
  output logic                        done,
  output logic [LAB1_NUM_VECTORS-1:0] truth_table,
  output logic                        mismatch
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [LAB1_VEC_W-1:0] LAST_IDX = '1;

  sweep_state_e                state_q, state_d;
  logic [LAB1_VEC_W-1:0]       idx_q, idx_d;
  logic [LAB1_VEC_W-1:0]       vec_q, vec_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [LAB1_NUM_VECTORS-1:0] tt_q, tt_d;
  logic                        mm_q, mm_d;

  // State register and all registered outputs, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
    end
  end

  // Next-state logic. done/busy/mismatch are registered on the edge that
  // enters DONE so they are visible while the FSM sits in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    mm_d    = mm_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          mm_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          vec_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          vec_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tt_d[idx_q] = f;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef LAB1_SWEEP_CHECK_EN
            // Compare against the table including this final bit-15 sample.
            mm_d    = (tt_d != expected_table);
`endif
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            vec_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifndef LAB1_SWEEP_CHECK_EN
  logic unused_expected;
  assign unused_expected = ^expected_table;
`endif

  assign {a, b, c, d}  = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign truth_table   = tt_q;
  assign mismatch      = mm_q;

endmodule

// File: tb/tb_lab1_sweep_controller.sv
// Directed bench for lab1_sweep_controller with a queue scoreboard of
// expected sweep outcomes.
module tb_lab1_sweep_controller;

`ifdef LAB1_SWEEP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] tt;
    logic        mm;
    int          done_at;
    int          done_cnt;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, abort0, start1, abort1, f_one;
  logic [15:0] exp_tab;
  logic        a0, b0, c0, d0, busy0, done0, mm0, f0;
  logic        a1, b1, c1, d1, busy1, done1, mm1, f1;
  logic [15:0] tt0, tt1;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  assign f0 = f_one ? 1'b1 : (a0 & b0);
  assign f1 = a1 ^ b1 ^ c1 ^ d1;

  lab1_sweep_controller #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f(f0),
    .expected_table(exp_tab), .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .truth_table(tt0), .mismatch(mm0)
  );

  lab1_sweep_controller #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f(f1),
    .expected_table(exp_tab), .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .truth_table(tt1), .mismatch(mm1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep on dut0 (SETTLE_CYCLES=2). Cycle n = 1 time unit after the
  // n-th edge following the edge that accepts start.
  task automatic run0(input string name, input logic [15:0] exp_tt, input logic exp_mm,
                      input bit full, input int restart_at, input int abort_at,
                      input int rst_at, input bit abort_with_start,
                      input logic [15:0] tab, input logic fone);
    exp_t r;
    int n, dc, da;
    r.tt = exp_tt; r.mm = exp_mm;
    r.done_at = full ? 48 : -1;
    r.done_cnt = full ? 1 : 0;
    sb.push_back(r);
    exp_tab = tab;
    f_one   = fone;
    start0  = 1'b1;
    abort0  = abort_with_start;
    tick();
    start0 = 1'b0;
    abort0 = 1'b0;
    chk({name, "_busy_c0"}, {31'd0, busy0}, 32'd1);
    n = 0; dc = 0; da = -1;
    while (n < 70) begin
      if (done0) begin
        dc++;
        if (da < 0) da = n;
        if (dc == 1) chk({name, "_mm_with_done"}, {31'd0, mm0}, {31'd0, exp_mm});
      end
      if (full && (n == 1 || n == 47)) chk({name, "_busy_mid"}, {31'd0, busy0}, 32'd1);
      if (full && n == 48) chk({name, "_busy_at_done"}, {31'd0, busy0}, 32'd0);
      if (abort_at > 0 && n == abort_at) begin
        chk({name, "_busy_after_abort"}, {31'd0, busy0}, 32'd0);
        chk({name, "_vec_after_abort"}, {28'd0, a0, b0, c0, d0}, 32'd0);
      end
      if (rst_at > 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, "_reset_outputs"}, {9'd0, tt0, a0, b0, c0, d0, busy0, done0, mm0}, 32'd0);
        #1;
        rst_n = 1'b1;
        break;
      end
      start0 = (n + 1 == restart_at);
      abort0 = (n + 1 == abort_at);
      tick();
      n++;
    end
    start0 = 1'b0;
    abort0 = 1'b0;
    if (full) chk({name, "_vec_held"}, {28'd0, a0, b0, c0, d0}, 32'hF);
    r = sb.pop_front();
    chk({name, "_done_cycle"}, da, r.done_at);
    chk({name, "_done_count"}, dc, r.done_cnt);
    chk({name, "_truth_table"}, {16'd0, tt0}, {16'd0, r.tt});
    chk({name, "_mismatch_held"}, {31'd0, mm0}, {31'd0, r.mm});
    tick();
  endtask

  task automatic run1();
    exp_t r;
    int n, dc, da;
    r.tt = 16'h6996; r.mm = 1'b0; r.done_at = 32; r.done_cnt = 1;
    sb.push_back(r);
    exp_tab = 16'h6996;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0; dc = 0; da = -1;
    while (n < 50) begin
      if (done1) begin
        dc++;
        if (da < 0) da = n;
      end
      tick();
      n++;
    end
    r = sb.pop_front();
    chk("xor_done_cycle", da, r.done_at);
    chk("xor_done_count", dc, r.done_cnt);
    chk("xor_truth_table", {16'd0, tt1}, {16'd0, r.tt});
    chk("xor_mismatch", {31'd0, mm1}, {31'd0, r.mm});
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    f_one = 1'b0; exp_tab = 16'hF000;
    #1;
    chk("reset_dut0", {9'd0, tt0, a0, b0, c0, d0, busy0, done0, mm0}, 32'd0);
    chk("reset_dut1", {9'd0, tt1, a1, b1, c1, d1, busy1, done1, mm1}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();

    run0("and_sweep", 16'hF000, 1'b0, 1'b1, 0, 0, 0, 1'b0, 16'hF000, 1'b0);
    run1();
    run0("restart_ignored", 16'hF000, 1'b0, 1'b1, 10, 0, 0, 1'b1, 16'hF000, 1'b0);
    run0("abort", 16'h003F, 1'b0, 1'b0, 0, 20, 0, 1'b0, 16'hF000, 1'b1);
    run0("mid_reset", 16'h0000, 1'b0, 1'b0, 0, 0, 25, 1'b0, 16'hF000, 1'b0);
    run0("post_reset", 16'hF000, 1'b0, 1'b1, 0, 0, 0, 1'b0, 16'hF000, 1'b0);
    run0("golden_diff", 16'hF000, CHK_EN, 1'b1, 0, 0, 0, 1'b0, 16'hF001, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
